// File: rtl/mod10_sched_pkg.sv
// Shared types and helpers for the mod-10 command scheduler: mode codes,
// FSM state encoding and the BCD digit step function.
package mod10_sched_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_INC1 = 2'b01;
    localparam logic [1:0] MODE_INC2 = 2'b10;
    localparam logic [1:0] MODE_DEC  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic logic [3:0] bcd_next(input logic [3:0] d, input logic [1:0] mode);
        logic [3:0] r;
        r = d;
        case (mode)
            MODE_HOLD: r = d;
            MODE_INC1: r = (d >= 4'd9) ? 4'd0 : d + 4'd1;
            MODE_INC2: begin
                if (d == 4'd8)      r = 4'd0;
                else if (d >= 4'd9) r = 4'd1;
                else                r = d + 4'd2;
            end
            MODE_DEC:  r = (d == 4'd0) ? 4'd9 : d - 4'd1;
            default:   r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mod10_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at the pointer,
// pointer moves one past the winner when advance is high.
module mod10_rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic            Clock,
    input  logic            resetn,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic          found;

    // First pass covers indices at/after the pointer, second pass the wrap-around.
    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (PW'(i) >= ptr_q)) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                ptr_d    = (i == NREQ - 1) ? '0 : PW'(i + 1);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i]) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                ptr_d    = (i == NREQ - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!resetn)      ptr_q <= '0;
        else if (advance) ptr_q <= ptr_d;
    end

endmodule

// File: rtl/mod10_cmd_scheduler.sv
// Shares one mod-10 counter between NREQ requesters, running one command at a time.
// Optional abort support is enabled with MOD10_SCHED_ABORT_EN.
module mod10_cmd_scheduler
    import mod10_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int CNT_W = 4
) (
    input  logic                    Clock,
    input  logic                    resetn,
    input  logic [NREQ-1:0]         req,
    input  logic [2*NREQ-1:0]       req_mode,
    input  logic [CNT_W*NREQ-1:0]   req_steps,
`ifdef MOD10_SCHED_ABORT_EN
    input  logic                    abort,
`endif
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic [1:0]              w_out,
    output logic                    step_en,
    output logic [3:0]              digit,
    output logic                    done,
`ifdef MOD10_SCHED_ABORT_EN
    output logic                    done_abort,
`endif
    output logic [$clog2(NREQ)-1:0] done_id
);

    // state   | meaning
    // IDLE    | waiting for requests; grants and latches a command
    // RUN     | one counter step per cycle until the count runs out
    // DONE    | one-cycle completion pulse with the requester id

    localparam int IDW = $clog2(NREQ);

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [3:0]       digit_q, digit_d;
`ifdef MOD10_SCHED_ABORT_EN
    logic             abort_q, abort_d;
`endif

    logic [NREQ-1:0]  arb_req;
    logic [NREQ-1:0]  grant;
    logic             advance;
    logic [IDW-1:0]   win_id;
    logic [1:0]       sel_mode;
    logic [CNT_W-1:0] sel_steps;

    // Gate with resetn so no grant is shown in a cycle whose edge will reset.
    assign arb_req = (state_q == ST_IDLE && resetn) ? req : '0;
    assign advance = |arb_req;

    mod10_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .Clock   (Clock),
        .resetn  (resetn),
        .req     (arb_req),
        .advance (advance),
        .grant   (grant)
    );

    always_comb begin
        win_id    = '0;
        sel_mode  = MODE_HOLD;
        sel_steps = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                win_id    = IDW'(i);
                sel_mode  = req_mode[2*i +: 2];
                sel_steps = req_steps[CNT_W*i +: CNT_W];
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_HOLD;
            cnt_q   <= '0;
            id_q    <= '0;
            digit_q <= 4'd0;
`ifdef MOD10_SCHED_ABORT_EN
            abort_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            digit_q <= digit_d;
`ifdef MOD10_SCHED_ABORT_EN
            abort_q <= abort_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        digit_d = digit_q;
`ifdef MOD10_SCHED_ABORT_EN
        abort_d = abort_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (advance) begin
                    mode_d  = sel_mode;
                    cnt_d   = sel_steps;
                    id_d    = win_id;
`ifdef MOD10_SCHED_ABORT_EN
                    abort_d = 1'b0;
`endif
                    state_d = (sel_steps != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
`ifdef MOD10_SCHED_ABORT_EN
                if (abort) begin
                    abort_d = 1'b1;
                    state_d = ST_DONE;
                end else
`endif
                begin
                    digit_d = bcd_next(digit_q, mode_q);
                    cnt_d   = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt     = grant;
        busy    = (state_q != ST_IDLE) || advance;
        step_en = (state_q == ST_RUN);
`ifdef MOD10_SCHED_ABORT_EN
        if (abort) step_en = 1'b0;
        done_abort = (state_q == ST_DONE) && abort_q;
`endif
        w_out   = step_en ? mode_q : MODE_HOLD;
        done    = (state_q == ST_DONE);
        done_id = done ? id_q : '0;
        digit   = digit_q;
    end

endmodule
